// File: rtl/axis_beam_combiner_pkg.sv
// beam_pkg: shared types, width helpers and output rounding for the beam combiner.
package beam_pkg;
  localparam int NUM_CH_D = 4;
  localparam int SAMPLE_W_D = 8;
  localparam int WEIGHT_W_D = 8;
  typedef struct packed {
    logic signed [SAMPLE_W_D-1:0] q;
    logic signed [SAMPLE_W_D-1:0] i;
  } cplx_t;
  typedef enum logic {F_IDLE, F_ACTIVE} frame_t;
  function automatic int prod_w(input int sw, input int ww);
    return sw + ww + 1;
  endfunction
  function automatic int acc_w(input int sw, input int ww, input int nch);
    return prod_w(sw, ww) + $clog2(nch);
  endfunction
  localparam int PROD_W = prod_w(SAMPLE_W_D, WEIGHT_W_D);
  localparam int ACC_W = acc_w(SAMPLE_W_D, WEIGHT_W_D, NUM_CH_D);
  // round half-up, arithmetic shift, clamp to a signed out_w range
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] x, input int shift,
                                                   input int out_w, output logic sat);
    logic signed [63:0] r, hi, lo;
    r = (x + ((shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0)) >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    sat = (r > hi) || (r < lo);
    return (r > hi) ? hi : (r < lo) ? lo : r;
  endfunction
endpackage

// File: rtl/axis_beam_combiner_cmplx_mac_lane.sv
// cmplx_mac_lane: one sample lane; complex multiply per channel, channel sum, round/saturate.
module cmplx_mac_lane
  import beam_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SAMPLE_W = 8,
  parameter int WEIGHT_W = 8,
  parameter int OUT_W = 8,
  parameter int SHIFT = 7
) (
  input  logic                         CLK,
  input  logic                         resetn,
  input  logic                         adv,
  input  logic [NUM_CH*2*SAMPLE_W-1:0] x,
  input  logic [NUM_CH*WEIGHT_W-1:0]   w_re,
  input  logic [NUM_CH*WEIGHT_W-1:0]   w_im,
  output logic [2*OUT_W-1:0]           y,
  output logic                         sat_d
);
  localparam int PW = prod_w(SAMPLE_W, WEIGHT_W);
  localparam int AW = acc_w(SAMPLE_W, WEIGHT_W, NUM_CH);
  logic signed [PW-1:0] pr_d [NUM_CH];
  logic signed [PW-1:0] pi_d [NUM_CH];
  logic signed [PW-1:0] pr_q [NUM_CH];
  logic signed [PW-1:0] pi_q [NUM_CH];
  logic signed [AW-1:0] sr_d, si_d, sr_q, si_q;
  logic [OUT_W-1:0] yr, yi;
  logic sr_sat, si_sat;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [PW-1:0] xi, xq, wr, wi;
    assign xi = PW'($signed(x[2*c*SAMPLE_W +: SAMPLE_W]));
    assign xq = PW'($signed(x[(2*c+1)*SAMPLE_W +: SAMPLE_W]));
    assign wr = PW'($signed(w_re[c*WEIGHT_W +: WEIGHT_W]));
    assign wi = PW'($signed(w_im[c*WEIGHT_W +: WEIGHT_W]));
    assign pr_d[c] = xi * wr - xq * wi;
    assign pi_d[c] = xi * wi + xq * wr;
  end
  always_comb begin
    sr_d = '0;
    si_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sr_d = sr_d + AW'(pr_q[c]);
      si_d = si_d + AW'(pi_q[c]);
    end
  end
  always_comb begin
    yr = OUT_W'(sat_round(64'(sr_q), SHIFT, OUT_W, sr_sat));
    yi = OUT_W'(sat_round(64'(si_q), SHIFT, OUT_W, si_sat));
    sat_d = sr_sat | si_sat;
  end
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      pr_q <= '{default: '0};
      pi_q <= '{default: '0};
      sr_q <= '0;
      si_q <= '0;
      y <= '0;
    end else if (adv) begin
      pr_q <= pr_d;
      pi_q <= pi_d;
      sr_q <= sr_d;
      si_q <= si_d;
      y <= {yi, yr};
    end
  end
endmodule

// File: rtl/axis_beam_combiner.sv
// axis_beam_combiner: joins NUM_CH I/Q streams, applies per-channel complex weights and sums them.
module axis_beam_combiner
  import beam_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SAMPLES = 8,
  parameter int SAMPLE_W = 8,
  parameter int WEIGHT_W = 8,
  parameter int OUT_W = 8,
  parameter int SHIFT = 7
) (
  input  logic                                 CLK,
  input  logic                                 resetn,
  input  logic [NUM_CH*SAMPLES*2*SAMPLE_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]                    s_axis_tvalid,
  input  logic [NUM_CH-1:0]                    s_axis_tlast,
  output logic [NUM_CH-1:0]                    s_axis_tready,
  input  logic [NUM_CH*WEIGHT_W-1:0]           weight_re,
  input  logic [NUM_CH*WEIGHT_W-1:0]           weight_im,
  input  logic                                 weight_load,
  output logic                                 weight_pending,
  output logic [SAMPLES*2*OUT_W-1:0]           m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  input  logic                                 clr_status,
  output logic                                 sat_flag,
  output logic                                 last_err
);
  logic adv, fire, commit, sat_set, v1, v2, l1, l2;
  logic [NUM_CH*WEIGHT_W-1:0] sh_re, sh_im, act_re, act_im, use_re, use_im;
  logic [SAMPLES-1:0] lane_sat;
  frame_t state, state_n;
  assign adv = !m_axis_tvalid || m_axis_tready;
  assign fire = (&s_axis_tvalid) && adv;
  assign s_axis_tready = {NUM_CH{fire}};
  // a beat firing in the commit cycle must already see the new weights
  assign commit = (state == F_IDLE) && weight_pending;
  assign use_re = commit ? sh_re : act_re;
  assign use_im = commit ? sh_im : act_im;
  assign sat_set = adv && v2 && (|lane_sat);
  always_comb begin
    state_n = state;
    if (fire) state_n = s_axis_tlast[0] ? F_IDLE : F_ACTIVE;
  end
  always_ff @(posedge CLK) begin
    if (!resetn) state <= F_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      sh_re <= '0;
      sh_im <= '0;
      act_re <= '0;
      act_im <= '0;
      weight_pending <= 1'b0;
      {v1, v2, m_axis_tvalid, l1, l2, m_axis_tlast} <= '0;
      sat_flag <= 1'b0;
      last_err <= 1'b0;
    end else begin
      if (weight_load) begin
        sh_re <= weight_re;
        sh_im <= weight_im;
      end
      if (commit) begin
        act_re <= sh_re;
        act_im <= sh_im;
      end
      weight_pending <= weight_load || (weight_pending && !commit);
      if (adv) begin
        v1 <= fire;
        v2 <= v1;
        m_axis_tvalid <= v2;
        l1 <= s_axis_tlast[0];
        l2 <= l1;
        m_axis_tlast <= l2;
      end
      sat_flag <= sat_set || (sat_flag && !clr_status);
      last_err <= (fire && (|s_axis_tlast) && !(&s_axis_tlast)) || (last_err && !clr_status);
    end
  end
  for (genvar k = 0; k < SAMPLES; k++) begin : g_lane
    logic [NUM_CH*2*SAMPLE_W-1:0] lx;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign lx[c*2*SAMPLE_W +: 2*SAMPLE_W] = s_axis_tdata[(c*SAMPLES+k)*2*SAMPLE_W +: 2*SAMPLE_W];
    end
    cmplx_mac_lane #(
      .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .WEIGHT_W(WEIGHT_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) u_lane (
      .CLK(CLK),
      .resetn(resetn),
      .adv(adv),
      .x(lx),
      .w_re(use_re),
      .w_im(use_im),
      .y(m_axis_tdata[k*2*OUT_W +: 2*OUT_W]),
      .sat_d(lane_sat[k])
    );
  end
endmodule

// File: tb/tb_axis_beam_combiner.sv
// tb_axis_beam_combiner: directed and random stimulus against an arithmetic reference model.
module tb_axis_beam_combiner;
  import beam_pkg::*;
  localparam int NC = 4, NS = 8, DW = NC*NS*16, OW = NS*16;
  logic CLK = 1'b0, resetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [NC-1:0] s_tvalid = '0, s_tlast = '0, s_tready;
  logic [31:0] w_re = '0, w_im = '0;
  logic w_load = 1'b0, w_pend;
  logic [OW-1:0] m_tdata;
  logic m_tvalid, m_tready = 1'b1, m_tlast, clr = 1'b0, sat_flag, last_err;
  int vec = 0, errs = 0, nout = 0, nsent = 0;
  logic [31:0] sh_re, sh_im, ac_re, ac_im, ur, ui;
  logic mp, inframe, ef, cm;
  logic [OW-1:0] qd[$];
  logic ql[$];

  axis_beam_combiner dut (
    .CLK(CLK), .resetn(resetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .weight_re(w_re), .weight_im(w_im), .weight_load(w_load), .weight_pending(w_pend),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .clr_status(clr), .sat_flag(sat_flag), .last_err(last_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // weighted sum per lane straight from the arithmetic definition
  function automatic logic [OW-1:0] beat(input logic [DW-1:0] d, input logic [31:0] wr, input logic [31:0] wi);
    logic [OW-1:0] o;
    int sr, si, xi, xq, a, b;
    o = '0;
    for (int k = 0; k < NS; k++) begin
      sr = 0;
      si = 0;
      for (int c = 0; c < NC; c++) begin
        xi = int'($signed(d[(c*NS+k)*16 +: 8]));
        xq = int'($signed(d[(c*NS+k)*16+8 +: 8]));
        a = int'($signed(wr[c*8 +: 8]));
        b = int'($signed(wi[c*8 +: 8]));
        sr += xi*a - xq*b;
        si += xi*b + xq*a;
      end
      sr = (sr + 64) >>> 7;
      si = (si + 64) >>> 7;
      sr = sr > 127 ? 127 : sr < -128 ? -128 : sr;
      si = si > 127 ? 127 : si < -128 ? -128 : si;
      o[k*16 +: 8] = sr[7:0];
      o[k*16+8 +: 8] = si[7:0];
    end
    return o;
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] d;
    for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [DW-1:0] base, input int c, input int i, input int q);
    logic [DW-1:0] d;
    cplx_t s;
    d = base;
    s.i = i[7:0];
    s.q = q[7:0];
    for (int k = 0; k < NS; k++) d[(c*NS+k)*16 +: 16] = s;
    return d;
  endfunction

  // scoreboard: model weight buffering and frame tracking, predict every output beat
  always @(negedge CLK) if (resetn) begin
    ef = (&s_tvalid) && (!m_tvalid || m_tready);
    cm = !inframe && mp;
    chk("s_tready", 128'(s_tready), 128'({NC{ef}}));
    chk("w_pending", 128'(w_pend), 128'(mp));
    if (m_tvalid && m_tready) begin
      chk("out_expected", 128'(qd.size() != 0), 128'(1));
      if (qd.size() != 0) begin
        chk("out_data", 128'(m_tdata), 128'(qd.pop_front()));
        chk("out_last", 128'(m_tlast), 128'(ql.pop_front()));
        nout++;
      end
    end
    ur = cm ? sh_re : ac_re;
    ui = cm ? sh_im : ac_im;
    if (ef) begin
      qd.push_back(beat(s_tdata, ur, ui));
      ql.push_back(s_tlast[0]);
      inframe = !s_tlast[0];
    end
    if (cm) begin
      ac_re = sh_re;
      ac_im = sh_im;
    end
    mp = w_load || (mp && !cm);
    if (w_load) begin
      sh_re = w_re;
      sh_im = w_im;
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [NC-1:0] l);
    int n;
    s_tdata = d;
    s_tlast = l;
    s_tvalid = '1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!(&s_tready) && n < 200);
    chk("send_accept", 128'(&s_tready), 128'(1));
    @(posedge CLK); #1;
    s_tvalid = '0;
    nsent++;
  endtask

  task automatic load(input logic [31:0] r, input logic [31:0] i);
    w_re = r;
    w_im = i;
    w_load = 1'b1;
    @(posedge CLK); #1;
    w_load = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [OW-1:0] ed, input logic el);
    int lat;
    lat = 0;
    do begin @(negedge CLK); lat++; end while (!m_tvalid && lat < 20);
    chk({tag, "_latency"}, 128'(lat), 128'(3));
    chk({tag, "_data"}, 128'(m_tdata), 128'(ed));
    chk({tag, "_last"}, 128'(m_tlast), 128'(el));
    @(posedge CLK); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (qd.size() != 0 && n < 100) begin @(negedge CLK); n++; end
    chk("drain", 128'(qd.size()), 128'(0));
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic done3, done7;
    int n, o0;
    resetn = 1'b0;
    mp = 1'b0;
    inframe = 1'b0;
    {sh_re, sh_im, ac_re, ac_im} = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_m_tdata", 128'(m_tdata), 128'(0));
    chk("rst_m_tlast", 128'(m_tlast), 128'(0));
    chk("rst_w_pending", 128'(w_pend), 128'(0));
    chk("rst_sat_flag", 128'(sat_flag), 128'(0));
    chk("rst_last_err", 128'(last_err), 128'(0));
    resetn = 1'b1;
    @(posedge CLK); #1;

    // ch0 weight 0.5: 100-j50 -> 50-j25
    load(32'h0000_0040, 32'h0);
    send(fill(rnd(), 0, 100, -50), 4'hF);
    wait_out("t1", {NS{16'hE732}}, 1'b1);
    chk("t1_sat_flag", 128'(sat_flag), 128'(0));
    chk("t1_last_err", 128'(last_err), 128'(0));

    // all channels near-unity weight, full-scale input -> saturation
    load(32'h7F7F_7F7F, 32'h0);
    send(fill(fill(fill(fill('0, 0, 127, 127), 1, 127, 127), 2, 127, 127), 3, 127, 127), 4'hF);
    wait_out("t2", {NS{16'h7F7F}}, 1'b1);
    chk("t2_sat_set", 128'(sat_flag), 128'(1));
    clr = 1'b1;
    @(posedge CLK); #1;
    clr = 1'b0;
    chk("t2_sat_clr", 128'(sat_flag), 128'(0));

    // backpressure: 4 beats offered while the sink stalls
    load($urandom, $urandom);
    @(posedge CLK); #1;
    drain();
    o0 = nout;
    m_tready = 1'b0;
    done3 = 1'b0;
    fork
      begin
        send(rnd(), 4'h0);
        send(rnd(), 4'h0);
        send(rnd(), 4'h0);
        send(rnd(), 4'hF);
        done3 = 1'b1;
      end
    join_none
    repeat (4) @(negedge CLK);
    chk("bp_head_n4", 128'(m_tdata), 128'(qd[0]));
    @(negedge CLK);
    chk("bp_tready", 128'(s_tready), 128'(0));
    chk("bp_valid", 128'(m_tvalid), 128'(1));
    chk("bp_head_n5", 128'(m_tdata), 128'(qd[0]));
    chk("bp_accepted", 128'(qd.size()), 128'(3));
    @(posedge CLK); #1;
    m_tready = 1'b1;
    n = 0;
    while (!done3 && n < 100) begin @(posedge CLK); #1; n++; end
    chk("bp_sent", 128'(done3), 128'(1));
    drain();
    chk("bp_count", 128'(nout - o0), 128'(4));

    // weight load mid-frame: rest of frame keeps 0.5, next frame gets 0.25
    load(32'h0000_0040, 32'h0);
    @(posedge CLK); #1;
    send(rnd(), 4'h0);
    load(32'h0000_0020, 32'h0);
    chk("t4_pending_mid", 128'(w_pend), 128'(1));
    send(rnd(), 4'h0);
    send(rnd(), 4'h0);
    chk("t4_pending_hold", 128'(w_pend), 128'(1));
    send(rnd(), 4'hF);
    drain();
    send(fill(rnd(), 0, 100, -50), 4'hF);
    wait_out("t4", {NS{16'hF419}}, 1'b1);
    chk("t4_pending_clr", 128'(w_pend), 128'(0));

    // one channel withholds valid: the join must wait
    d = rnd();
    s_tdata = d;
    s_tlast = 4'hF;
    s_tvalid = 4'b1011;
    repeat (3) begin
      @(negedge CLK);
      chk("t5_join_hold", 128'(s_tready), 128'(0));
    end
    @(posedge CLK); #1;
    send(d, 4'hF);
    drain();

    // mismatched tlast
    d = rnd();
    send(d, 4'b0001);
    wait_out("t6", beat(d, 32'h0000_0020, 32'h0), 1'b1);
    chk("t6_last_err", 128'(last_err), 128'(1));
    load(32'h0000_0040, 32'h0);
    @(posedge CLK); #1;
    chk("t6_idle_commit", 128'(w_pend), 128'(0));
    clr = 1'b1;
    @(posedge CLK); #1;
    clr = 1'b0;
    chk("t6_err_clr", 128'(last_err), 128'(0));

    // random traffic, random weights and sink stalls
    done7 = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          if ($urandom_range(0, 4) == 0) load($urandom, $urandom);
          send(rnd(), ($urandom_range(0, 2) == 0) ? 4'hF : 4'h0);
        end
        done7 = 1'b1;
      end
      begin
        while (!done7) begin
          @(posedge CLK); #1;
          m_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_tready = 1'b1;
    drain();
    chk("total_out", 128'(nout), 128'(nsent));
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/axis_beam_combiner.md
Name: axis_beam_combiner

Overview:
- Parametrised complex weighted-sum (beamforming) combiner with NUM_CH AXI-Stream input channels and one AXI-Stream output.
- Each beat carries SAMPLES complex I/Q samples per channel. Each channel is multiplied by its own complex weight and the results are summed across channels.
- The sum is rounded, shifted and saturated to OUT_W.
- Weights are double-buffered and switch only on frame (tlast) boundaries. It sits between the per-antenna channelisers and the downstream DMA.

Parameters:
- NUM_CH, 4, number of input channels.
- SAMPLES, 8, complex samples per beat.
- SAMPLE_W, 8, signed width of each I or Q component in.
- WEIGHT_W, 8, signed weight component width, Q1.(WEIGHT_W-1).
- OUT_W, 8, signed width of each I or Q component out.
- SHIFT, 7, arithmetic right shift applied after accumulation.

Ports:
- CLK  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  NUM_CH*SAMPLES*2*SAMPLE_W  channel c at slice c; sample k: I at [2k*SAMPLE_W], Q above it.
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tlast  in  NUM_CH  per-channel last.
- s_axis_tready  out  NUM_CH  per-channel ready.
- weight_re  in  NUM_CH*WEIGHT_W  pending real weights.
- weight_im  in  NUM_CH*WEIGHT_W  pending imaginary weights.
- weight_load  in  1  capture weight_re/weight_im into the shadow register.
- weight_pending  out  1  shadow weights not yet active.
- m_axis_tdata  out  SAMPLES*2*OUT_W  combined samples, same packing as the inputs.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output last.
- clr_status  in  1  clear the sticky flags.
- sat_flag  out  1  sticky: a saturation occurred.
- last_err  out  1  sticky: channels disagreed on tlast.

Behaviour:
- Reset (resetn=0 at CLK edge):
  - All outputs are 0.
  - Active and shadow weights are 0.
  - Pipeline valid bits are 0.
  - The frame FSM goes to F_IDLE.
- Pipeline advance: adv = !m_axis_tvalid || m_axis_tready. The whole pipeline stalls as a unit, and no data is lost under backpressure.
- Join:
  - fire = (&s_axis_tvalid) && adv.
  - s_axis_tready[c] = fire for every c, so all channels are consumed together.
  - Ready depends on valid, which is permitted here.
- Stage 1 (registered on fire):
  - Complex product per channel and sample: re = xI*wR - xQ*wI, im = xI*wI + xQ*wR.
  - Product width is SAMPLE_W+WEIGHT_W+1, signed.
- Stage 2: sum across channels, width SAMPLE_W+WEIGHT_W+1+clog2(NUM_CH). The sum never overflows.
- Stage 3:
  - Round half-up: add 1<<(SHIFT-1) when SHIFT>0.
  - Arithmetic shift right by SHIFT.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Any saturated component sets sat_flag.
- Latency: 3 cycles from fire to m_axis_tvalid, provided there is no backpressure. Throughput is 1 beat per cycle.
- m_axis_tlast is s_axis_tlast[0], piped alongside the data.
- last_err is set on any fire where s_axis_tlast is neither all-0 nor all-1.
- Sticky flags:
  - clr_status clears both flags.
  - If a set event and clr_status occur in the same cycle, the set wins.
- Weight load:
  - weight_load=1 captures the inputs into the shadow register and sets weight_pending.
  - A repeated load before commit overwrites the shadow register.
- Frame FSM:
  - F_IDLE → F_ACTIVE on a fire with tlast[0]=0.
  - F_ACTIVE → F_IDLE on a fire with tlast[0]=1.
  - A single-beat frame (fire with tlast[0]=1 in F_IDLE) stays in F_IDLE.
- Commit:
  - In F_IDLE with weight_pending=1 and no fire this cycle: active ← shadow and weight_pending clears.
  - If a fire occurs in F_IDLE with weight_pending=1, commit happens in the same cycle and that beat uses the new weights.
  - Active weights never change while in F_ACTIVE.
  - If weight_load and commit occur in the same cycle, the old shadow is committed and the new value stays pending.
- Reset mid-frame discards all in-flight beats. Upstream must re-align its channels.

Decomposition:
- Package beam_pkg holds:
  - the complex sample struct type;
  - the product and accumulator width localparams as functions of the parameters;
  - the sat_round function;
  - frame state enum {F_IDLE, F_ACTIVE}.
- One sub-module, cmplx_mac_lane: a single sample lane covering stages 1–3 for all channels. It is instantiated SAMPLES times.
- The join, frame FSM, weight buffering and flags stay in the top level.

Test Plan:
- Weights: ch0 = 0x40+j0 (0.5), others 0. Input ch0 sample = 100+j(-50), m_tready=1.
  → Output 50+j(-25) exactly 3 cycles after fire.
- All four channels w = 0x7F+j0, each input 127+j127.
  → Output saturates to 127+j127 and sat_flag=1; clr_status then clears sat_flag.
- Hold m_tready=0 for 5 cycles with 4 beats offered.
  → s_tready drops once the pipeline is full, the output holds stable, and all 4 beats emerge in order with none lost or duplicated.
- weight_load (w0 = 0x40→0x20) mid-frame of 4 beats.
  → weight_pending=1 and the remaining beats use 0.5; the first beat of the next frame uses 0.25 and weight_pending clears.
- Only ch2 tvalid deasserted for 3 cycles.
  → No fire and s_tready all 0; the join resumes when ch2 reasserts.
- Beat with tlast=4'b0001.
  → last_err=1 and m_tlast=1; the frame FSM returns to F_IDLE.
